// File: rtl/fxp_divider_if.sv
// Request/response bundle for the fixed-point divider: operands and mode in,
// quotient, remainder and status flags out.
interface fxp_divider_if #(
  parameter int W  = 16,
  parameter int SW = $clog2(W)
);
  logic          start;
  logic [1:0]    mode;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic [SW-1:0] frac;
  logic          busy;
  logic          done;
  logic [W-1:0]  quot;
  logic [W-1:0]  rem;
  logic          ovf;
  logic          dz;

  modport master (
    output start, mode, dividend, divisor, frac,
    input  busy, done, quot, rem, ovf, dz
  );

  modport slave (
    input  start, mode, dividend, divisor, frac,
    output busy, done, quot, rem, ovf, dz
  );
endinterface

// File: rtl/fxp_divider.sv
// Sequential signed fixed-point divider: (a * 2^f) / b by restoring division,
// one quotient bit per clock, with optional round-half-away and saturation.
module fxp_divider #(
  parameter int W  = 16,
  parameter int SW = $clog2(W)
) (
  input  logic        clk,
  input  logic        rst,
  fxp_divider_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int         CW     = $clog2(2 * W) + 1;

  logic [1:0]     state;
  logic [W-1:0]   num;        // |a| bits, consumed MSB first; the f trailing zeros shift in
  logic [W-1:0]   bmag;
  logic [W-1:0]   r;
  logic [2*W-1:0] q;
  logic [CW-1:0]  cnt;
  logic           sa, sb, rnd, done_pend;

  logic [W-1:0]   amag, dmag;
  logic [CW-1:0]  f_eff;
  logic [W:0]     trial, diff;
  logic           ge;
  logic [W-1:0]   r_next;
  logic           inc, neg, sat_pos, sat_neg;
  logic [2*W:0]   q_rnd;
  logic [W-1:0]   quot_fix, rem_fix;

  assign amag  = bus.dividend[W-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dmag  = bus.divisor[W-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
  assign f_eff = (int'(bus.frac) >= W) ? CW'(W - 1) : CW'(bus.frac);

  // One restoring step: shift the next numerator bit in, subtract if it fits.
  assign trial  = {r, num[W-1]};
  assign ge     = trial >= {1'b0, bmag};
  assign diff   = trial - {1'b0, bmag};
  assign r_next = ge ? diff[W-1:0] : trial[W-1:0];

  // Rounding, sign application and saturation, all evaluated in FIX.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    inc      = rnd && ({r, 1'b0} >= {1'b0, bmag});
    q_rnd    = {1'b0, q} + {{(2*W){1'b0}}, inc};
    neg      = sa ^ sb;
    sat_pos  = |q_rnd[2*W:W-1];
    sat_neg  = (|q_rnd[2*W:W]) || (q_rnd[W-1] && (|q_rnd[W-2:0]));
    quot_fix = q_rnd[W-1:0];
    if (!neg && sat_pos)
      quot_fix = {1'b0, {(W-1){1'b1}}};
    else if (neg && sat_neg)
      quot_fix = {1'b1, {(W-1){1'b0}}};
    else if (neg)
      quot_fix = ~q_rnd[W-1:0] + 1'b1;
    rem_fix  = sa ? (~r + 1'b1) : r;
  end

  assign bus.busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      num       <= '0;
      bmag      <= '0;
      r         <= '0;
      q         <= '0;
      cnt       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      rnd       <= 1'b0;
      done_pend <= 1'b0;
      bus.done  <= 1'b0;
      bus.quot  <= '0;
      bus.rem   <= '0;
      bus.ovf   <= 1'b0;
      bus.dz    <= 1'b0;
    end else begin
      bus.done  <= done_pend;
      done_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.mode == 2'b01 || bus.mode == 2'b10) begin
              bus.quot  <= (bus.mode == 2'b01) ? bus.dividend : bus.divisor;
              bus.rem   <= '0;
              bus.ovf   <= 1'b0;
              bus.dz    <= 1'b0;
              done_pend <= 1'b1;
            end else if (bus.divisor == '0) begin
              bus.quot  <= bus.dividend[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
              bus.rem   <= '0;
              bus.ovf   <= 1'b0;
              bus.dz    <= 1'b1;
              done_pend <= 1'b1;
            end else begin
              num   <= amag;
              bmag  <= dmag;
              sa    <= bus.dividend[W-1];
              sb    <= bus.divisor[W-1];
              rnd   <= bus.mode[1];
              r     <= '0;
              q     <= '0;
              cnt   <= CW'(W) + f_eff;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          num <= {num[W-2:0], 1'b0};
          r   <= r_next;
          q   <= {q[2*W-2:0], ge};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          bus.quot <= quot_fix;
          bus.rem  <= rem_fix;
          bus.ovf  <= neg ? sat_neg : sat_pos;
          bus.dz   <= 1'b0;
          bus.done <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
